// File: rtl/sign_extender.sv
// Registered immediate generator: extracts the I/D/B/CB immediate field and extends it to 64 bits.
// Optional ImmNeg/ImmZero flag outputs are enabled with `define SIGN_EXTENDER_FLAGS_EN.
module sign_extender (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        InValid,
   input  logic [25:0] Imm,
   input  logic [1:0]  Ctrl,
`ifdef SIGN_EXTENDER_FLAGS_EN
   output logic        ImmNeg,
   output logic        ImmZero,
`endif
   output logic [63:0] BusImm,
   output logic        OutValid
);

   typedef enum logic [1:0] {
      FmtI  = 2'b00,
      FmtD  = 2'b01,
      FmtB  = 2'b10,
      FmtCb = 2'b11
   } fmt_e;

   fmt_e        fmt;
   logic [63:0] imm_d;

   assign fmt = fmt_e'(Ctrl);

   always_comb begin
      imm_d = '0;
      unique case (fmt)
         FmtI:  imm_d = {52'b0, Imm[21:10]};
         FmtD:  imm_d = {{55{Imm[20]}}, Imm[20:12]};
         // Branch offsets are word offsets; append two zero bits after extension.
         FmtB:  imm_d = {{36{Imm[25]}}, Imm[25:0], 2'b00};
         FmtCb: imm_d = {{43{Imm[23]}}, Imm[23:5], 2'b00};
         default: imm_d = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         BusImm   <= '0;
         OutValid <= 1'b0;
      end else begin
         OutValid <= InValid;
         if (InValid) begin
            BusImm <= imm_d;
         end
      end
   end

`ifdef SIGN_EXTENDER_FLAGS_EN
   // Flags are derived from the next value so they line up with BusImm exactly.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         ImmNeg  <= 1'b0;
         ImmZero <= 1'b1;
      end else if (InValid) begin
         ImmNeg  <= imm_d[63];
         ImmZero <= (imm_d == 64'd0);
      end
   end
`endif

endmodule

// File: tb/tb_sign_extender.sv
// Directed self-checking bench for sign_extender.
module tb_sign_extender;

   logic        CLK;
   logic        Reset;
   logic        InValid;
   logic [25:0] Imm;
   logic [1:0]  Ctrl;
   logic [63:0] BusImm;
   logic        OutValid;
`ifdef SIGN_EXTENDER_FLAGS_EN
   logic        ImmNeg;
   logic        ImmZero;
`endif

   int checks = 0;
   int errors = 0;

   sign_extender dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .InValid  (InValid),
      .Imm      (Imm),
      .Ctrl     (Ctrl),
`ifdef SIGN_EXTENDER_FLAGS_EN
      .ImmNeg   (ImmNeg),
      .ImmZero  (ImmZero),
`endif
      .BusImm   (BusImm),
      .OutValid (OutValid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic [63:0] exp);
`ifdef SIGN_EXTENDER_FLAGS_EN
      check({tag, ".neg"}, {63'b0, ImmNeg}, {63'b0, exp[63]});
      check({tag, ".zero"}, {63'b0, ImmZero}, {63'b0, (exp == 64'd0)});
`else
      if (exp === 64'hx) $display("unreachable %s", tag);
`endif
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic capture(input string tag, input logic [1:0] c, input logic [25:0] i,
                          input logic [63:0] exp);
      Ctrl    = c;
      Imm     = i;
      InValid = 1'b1;
      tick();
      check(tag, BusImm, exp);
      check({tag, ".vld"}, {63'b0, OutValid}, 64'd1);
      check_flags(tag, exp);
   endtask

   typedef struct {
      string       tag;
      logic [1:0]  ctrl;
      logic [25:0] imm;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{"i_ones",  2'b00, 26'h3FFFFFF, 64'h0000000000000FFF};
      vecs[1]  = '{"i_123",   2'b00, 26'h0048C00, 64'h0000000000000123};
      vecs[2]  = '{"i_zero",  2'b00, 26'h0000000, 64'h0000000000000000};
      vecs[3]  = '{"d_ones",  2'b01, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFF};
      vecs[4]  = '{"d_ff",    2'b01, 26'h00FF000, 64'h00000000000000FF};
      vecs[5]  = '{"d_zero",  2'b01, 26'h0000000, 64'h0000000000000000};
      vecs[6]  = '{"b_ones",  2'b10, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFC};
      vecs[7]  = '{"b_one",   2'b10, 26'h0000001, 64'h0000000000000004};
      vecs[8]  = '{"b_min",   2'b10, 26'h2000000, 64'hFFFFFFFFF8000000};
      vecs[9]  = '{"cb_ones", 2'b11, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFC};
      vecs[10] = '{"cb_min",  2'b11, 26'h0800000, 64'hFFFFFFFFFFF00000};
      vecs[11] = '{"cb_zero", 2'b11, 26'h0000000, 64'h0000000000000000};

      Reset   = 1'b1;
      InValid = 1'b0;
      Imm     = 26'h3FFFFFF;
      Ctrl    = 2'b10;
      tick();
      tick();
      check("rst.bus", BusImm, 64'd0);
      check("rst.vld", {63'b0, OutValid}, 64'd0);
      check_flags("rst", 64'd0);

      Reset = 1'b0;
      tick();
      check("idle.bus", BusImm, 64'd0);
      check("idle.vld", {63'b0, OutValid}, 64'd0);
      check_flags("idle", 64'd0);

      foreach (vecs[k]) capture(vecs[k].tag, vecs[k].ctrl, vecs[k].imm, vecs[k].exp);

      // Hold: output must not follow Imm/Ctrl while InValid is low.
      capture("hold.cap", 2'b11, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFC);
      InValid = 1'b0;
      for (int n = 0; n < 3; n++) begin
         Imm  = 26'h0000001 << (n * 7);
         Ctrl = 2'(n);
         tick();
         check("hold.bus", BusImm, 64'hFFFFFFFFFFFFFFFC);
         check("hold.vld", {63'b0, OutValid}, 64'd0);
         check_flags("hold", 64'hFFFFFFFFFFFFFFFC);
      end

      // Reset wins over a simultaneous valid capture.
      Reset   = 1'b1;
      InValid = 1'b1;
      Ctrl    = 2'b11;
      Imm     = 26'h3FFFFFF;
      tick();
      check("rstpri.bus", BusImm, 64'd0);
      check("rstpri.vld", {63'b0, OutValid}, 64'd0);
      check_flags("rstpri", 64'd0);

      Reset = 1'b0;
      capture("post_rst", 2'b10, 26'h0000001, 64'h0000000000000004);
      InValid = 1'b0;
      tick();
      check("post_rst.hold", BusImm, 64'h0000000000000004);
      check("post_rst.vld", {63'b0, OutValid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
